// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle data-memory access stage.
// Takes a decoded memory-control code, the ALU byte address and rs2 store
// data. Runs a req/ready/rvalid handshake to data memory, builds byte enables
// and lane-replicated store data, and sign/zero-extends load results. Holds
// the pipeline (oStall) until the access completes.
// Ports:
//   iClk, iRst                 clock (rising edge), async active-high reset
//   iStart, iMemControl        op strobe and 4-bit code (0-7 valid, else no-op)
//   iAddr, iStoreData          byte address, rs2 value
//   oStall, oDone, oFault      pipeline hold, completion pulse, fault pulse
//   oLoadData                  extended load result, held until next load
//   oMemReq/We/Addr/Be/Wdata   memory request side
//   iMemReady, iMemRvalid,
//   iMemRdata                  memory accept, read-valid, read word
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [3:0]        iMemControl,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [31:0]       iStoreData,
  output logic              oStall,
  output logic              oDone,
  output logic              oFault,
  output logic [31:0]       oLoadData,
  output logic              oMemReq,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [3:0]        oMemBe,
  output logic [31:0]       oMemWdata,
  input  logic              iMemReady,
  input  logic              iMemRvalid,
  input  logic [31:0]       iMemRdata
);
  localparam logic [3:0] C_LW = 4'd0, C_LH = 4'd1, C_LB = 4'd2, C_LHU = 4'd3,
                         C_LBU = 4'd4, C_SW = 4'd5, C_SH = 4'd6, C_SB = 4'd7;

  // Counter is one bit wider than needed so TIMEOUT_CYCLES=0 still elaborates.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_FAULT} state_t;

  state_t        state;
  logic [3:0]    code_q;
  logic [1:0]    off_q;
  logic [CW-1:0] wait_cnt;

  // Incoming-op decode, only meaningful while IDLE.
  logic [1:0] off;
  logic       op_valid, is_store, is_word, is_half, misaligned;
  assign off        = iAddr[1:0];
  assign op_valid   = ~iMemControl[3];
  assign is_store   = (iMemControl == C_SW) | (iMemControl == C_SH) | (iMemControl == C_SB);
  assign is_word    = (iMemControl == C_LW) | (iMemControl == C_SW);
  assign is_half    = (iMemControl == C_LH) | (iMemControl == C_LHU) | (iMemControl == C_SH);
  assign misaligned = (is_word & (off != 2'b00)) | (is_half & off[0]);

  // Per byte lane: enable and replicated store data. Loads take all lanes.
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    assign be_n[i] = (iMemControl == C_SB) ? (off == LANE) :
                     (iMemControl == C_SH) ? (off[1] == LANE[1]) : 1'b1;
    assign wdata_n[8*i +: 8] = (iMemControl == C_SB) ? iStoreData[7:0] :
                               (iMemControl == C_SH) ? iStoreData[8*(i%2) +: 8] :
                               iStoreData[8*i +: 8];
  end

  // Shift the addressed lane down to bit 0, then extend.
  logic [31:0] lane, load_ext;
  assign lane = iMemRdata >> {off_q, 3'b000};
  always_comb begin
    load_ext = iMemRdata;
    case (code_q)
      C_LB:    load_ext = {{24{lane[7]}}, lane[7:0]};
      C_LBU:   load_ext = {24'h0, lane[7:0]};
      C_LH:    load_ext = {{16{lane[15]}}, lane[15:0]};
      C_LHU:   load_ext = {16'h0, lane[15:0]};
      default: load_ext = iMemRdata;
    endcase
  end

  // The start-cycle term is combinational so the op is held the cycle it is presented.
  assign oStall = ~iRst & ((state == S_IDLE & iStart & op_valid) |
                           (state == S_REQ) | (state == S_WAIT));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= S_IDLE;
      code_q    <= 4'h0;
      off_q     <= 2'b00;
      wait_cnt  <= '0;
      oDone     <= 1'b0;
      oFault    <= 1'b0;
      oLoadData <= 32'h0;
      oMemReq   <= 1'b0;
      oMemWe    <= 1'b0;
      oMemAddr  <= '0;
      oMemBe    <= 4'h0;
      oMemWdata <= 32'h0;
    end else begin
      oDone  <= 1'b0;
      oFault <= 1'b0;
      case (state)
        S_IDLE: if (iStart && op_valid) begin
          code_q <= iMemControl;
          off_q  <= off;
          if (misaligned) begin
            state  <= S_FAULT;
            oDone  <= 1'b1;
            oFault <= 1'b1;
          end else begin
            state     <= S_REQ;
            oMemReq   <= 1'b1;
            oMemWe    <= is_store;
            oMemAddr  <= {iAddr[ADDR_W-1:2], 2'b00};
            oMemBe    <= be_n;
            oMemWdata <= wdata_n;
          end
        end
        S_REQ: if (iMemReady) begin
          oMemReq <= 1'b0;
          if (oMemWe || iMemRvalid) begin
            state <= S_DONE;
            oDone <= 1'b1;
            if (!oMemWe) oLoadData <= load_ext;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (iMemRvalid) begin
            state     <= S_DONE;
            oDone     <= 1'b1;
            oLoadData <= load_ext;
            wait_cnt  <= '0;
          end else if (TIMEOUT_CYCLES != 0 && wait_cnt == TO_LAST) begin
            state    <= S_FAULT;
            oDone    <= 1'b1;
            oFault   <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DONE, S_FAULT: state <= S_IDLE;
        default:         state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        iClk = 1'b0, iRst = 1'b1;
  logic        iStart = 1'b0;
  logic [3:0]  iMemControl = 4'h8;
  logic [31:0] iAddr = 32'h0, iStoreData = 32'h0;
  logic        oStall, oDone, oFault, oMemReq, oMemWe;
  logic [31:0] oLoadData, oMemAddr, oMemWdata;
  logic [3:0]  oMemBe;
  logic        iMemReady = 1'b0, iMemRvalid = 1'b0;
  logic [31:0] iMemRdata = 32'h0;

  int checks = 0, failures = 0;
  logic [31:0] exp_load = 32'h0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iMemControl(iMemControl),
    .iAddr(iAddr), .iStoreData(iStoreData), .oStall(oStall), .oDone(oDone),
    .oFault(oFault), .oLoadData(oLoadData), .oMemReq(oMemReq), .oMemWe(oMemWe),
    .oMemAddr(oMemAddr), .oMemBe(oMemBe), .oMemWdata(oMemWdata),
    .iMemReady(iMemReady), .iMemRvalid(iMemRvalid), .iMemRdata(iMemRdata));

  always #5 iClk = ~iClk;

  // Reference load result straight from the ISA rules.
  function automatic logic [31:0] ref_load(input logic [3:0] code, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [31:0] sh, b, h;
    sh = w >> (8 * (addr % 4));
    b  = sh & 32'hFF;
    h  = sh & 32'hFFFF;
    case (code)
      4'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      4'd2:    return (b >= 32'h80) ? b - 32'h100 : b;
      4'd3:    return h;
      4'd4:    return b;
      default: return w;
    endcase
  endfunction

  // One memory op. rd = cycles of ready low before ready; vd = cycles from
  // the ready cycle to rvalid (0 = same cycle). hold = present a new op in
  // the DONE cycle, which must be ignored.
  task automatic run_op(input logic [3:0] code, input logic [31:0] addr, input logic [31:0] d,
                        input int rd, input int vd, input logic [31:0] rdata, input bit hold);
    int size, nw;
    bit mis, is_load, tout;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    size    = (code == 4'd0 || code == 4'd5) ? 4 :
              (code == 4'd1 || code == 4'd3 || code == 4'd6) ? 2 : 1;
    mis     = (addr % size) != 0;
    is_load = code < 4'd5;
    e_be    = (code == 4'd7) ? 4'(1 << (addr % 4)) : (code == 4'd6) ? 4'(3 << (addr % 4)) : 4'hF;
    e_wd    = (code == 4'd7) ? (d & 32'hFF) * 32'h01010101 :
              (code == 4'd6) ? (d & 32'hFFFF) * 32'h00010001 : d;
    tout    = is_load && TO != 0 && vd > TO;
    nw      = (!is_load || vd == 0) ? 0 : (tout ? TO : vd);

    @(posedge iClk); #1;
    iStart = 1'b1; iMemControl = code; iAddr = addr; iStoreData = d;
    iMemReady = 1'b0; iMemRvalid = 1'b0;
    @(negedge iClk);
    checks++;
    if ({oStall, oMemReq, oDone} !== 3'b100) begin
      failures++; $display("FAIL start_cycle code=%0d: stall/req/done=%b exp 100", code, {oStall, oMemReq, oDone});
    end

    if (mis) begin
      @(posedge iClk); #1;
      iStart = 1'b0; iAddr = $urandom;
      @(negedge iClk);
      checks++;
      if ({oStall, oMemReq, oDone, oFault, oLoadData} !== {4'b0011, exp_load}) begin
        failures++;
        $display("FAIL misalign code=%0d addr=%h: s/r/d/f=%b load=%h exp 0011 %h",
                 code, addr, {oStall, oMemReq, oDone, oFault}, oLoadData, exp_load);
      end
      return;
    end

    for (int c = 0; c <= rd; c++) begin
      @(posedge iClk); #1;
      iStart = 1'($urandom); iMemControl = 4'($urandom); iAddr = $urandom; iStoreData = $urandom;
      iMemReady  = (c == rd);
      iMemRvalid = is_load && c == rd && vd == 0;
      iMemRdata  = iMemRvalid ? rdata : $urandom;
      @(negedge iClk);
      checks++;
      if ({oStall, oMemReq, oDone, oFault, oMemWe, oMemBe, oMemAddr} !==
          {4'b1100, !is_load, e_be, addr & 32'hFFFF_FFFC}) begin
        failures++;
        $display("FAIL req code=%0d: s/r/d/f=%b we=%b be=%b addr=%h exp we=%b be=%b addr=%h",
                 code, {oStall, oMemReq, oDone, oFault}, oMemWe, oMemBe, oMemAddr,
                 !is_load, e_be, addr & 32'hFFFF_FFFC);
      end
      if (!is_load) begin
        checks++;
        if (oMemWdata !== e_wd) begin
          failures++; $display("FAIL wdata code=%0d: got %h exp %h", code, oMemWdata, e_wd);
        end
      end
    end

    for (int w = 1; w <= nw; w++) begin
      @(posedge iClk); #1;
      iStart = 1'($urandom); iMemControl = 4'($urandom); iMemReady = 1'($urandom);
      iMemRvalid = !tout && w == vd;
      iMemRdata  = iMemRvalid ? rdata : $urandom;
      @(negedge iClk);
      checks++;
      if ({oStall, oMemReq, oDone, oFault} !== 4'b1000) begin
        failures++; $display("FAIL wait cyc=%0d: s/r/d/f=%b exp 1000", w, {oStall, oMemReq, oDone, oFault});
      end
    end

    @(posedge iClk); #1;
    iStart = hold; iMemControl = 4'd5; iAddr = 32'h44; iMemReady = 1'b0; iMemRvalid = 1'b0;
    iMemRdata = $urandom;
    if (is_load && !tout) exp_load = ref_load(code, addr, rdata);
    @(negedge iClk);
    checks++;
    if ({oStall, oMemReq, oDone, oFault, oLoadData} !== {3'b001, tout, exp_load}) begin
      failures++;
      $display("FAIL done code=%0d: s/r/d/f=%b load=%h exp %b %h", code,
               {oStall, oMemReq, oDone, oFault}, oLoadData, {3'b001, tout}, exp_load);
    end
    if (hold) begin
      @(posedge iClk); #1;
      iStart = 1'b0;
      @(negedge iClk);
      checks++;
      if ({oStall, oMemReq, oDone} !== 3'b000) begin
        failures++; $display("FAIL start_in_done_ignored: s/r/d=%b exp 000", {oStall, oMemReq, oDone});
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge iClk);
    checks++;
    if ({oStall, oDone, oFault, oMemReq, oMemWe, oMemBe, oMemAddr, oMemWdata, oLoadData} !== '0) begin
      failures++; $display("FAIL reset_outputs: some output nonzero, load=%h addr=%h", oLoadData, oMemAddr);
    end
    iRst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(4'd5, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 0);          // SW
    run_op(4'd7, 32'h103, 32'h000000A5, 1, 0, 32'h0, 0);          // SB lane 3
    run_op(4'd2, 32'h102, 32'h0, 0, 3, 32'h0080FF00, 0);          // LB -> FFFFFF80
    run_op(4'd3, 32'h102, 32'h0, 0, 0, 32'h0080FF00, 0);          // LHU -> 00000080
    run_op(4'd0, 32'h100, 32'h0, 2, 1, 32'h0080FF00, 0);          // LW
    run_op(4'd1, 32'h101, 32'h0, 0, 0, 32'h0, 0);                 // LH misaligned
    run_op(4'd6, 32'h202, 32'h1234ABCD, 0, 0, 32'h0, 1);          // SH upper half
  endtask

  task automatic test_noop();
    @(posedge iClk); #1;
    iStart = 1'b1; iMemControl = 4'h8; iAddr = 32'h101;
    @(negedge iClk);
    checks++;
    if (oStall !== 1'b0) begin failures++; $display("FAIL noop_stall: got %b exp 0", oStall); end
    @(posedge iClk); #1;
    iMemControl = 4'hB;
    @(negedge iClk);
    checks++;
    if ({oStall, oMemReq, oDone} !== 3'b000) begin
      failures++; $display("FAIL noop_code8: s/r/d=%b exp 000", {oStall, oMemReq, oDone});
    end
    @(posedge iClk); #1;
    iStart = 1'b0;
    @(negedge iClk);
    checks++;
    if ({oStall, oMemReq, oDone, oFault} !== 4'b0000) begin
      failures++; $display("FAIL noop_code11: s/r/d/f=%b exp 0000", {oStall, oMemReq, oDone, oFault});
    end
  endtask

  task automatic test_timeout();
    run_op(4'd0, 32'h40, 32'h0, 0, 1000, 32'h0, 0);
    run_op(4'd4, 32'h41, 32'h0, 1, TO, 32'h000055F0, 0);           // rvalid on last allowed cycle
  endtask

  task automatic test_reset_mid();
    @(posedge iClk); #1;
    iStart = 1'b1; iMemControl = 4'd0; iAddr = 32'h300;
    @(posedge iClk); #1;
    iStart = 1'b0; iMemReady = 1'b1;
    @(posedge iClk); #1;
    iMemReady = 1'b0;
    @(posedge iClk); #2;
    checks++;
    if ({oStall, oMemReq} !== 2'b10) begin
      failures++; $display("FAIL pre_reset_wait: stall/req=%b exp 10", {oStall, oMemReq});
    end
    iRst = 1'b1; #1;
    checks++;
    if ({oStall, oDone, oFault, oMemReq, oMemWe, oMemBe, oMemAddr, oMemWdata, oLoadData} !== '0) begin
      failures++; $display("FAIL async_reset: load=%h addr=%h stall=%b", oLoadData, oMemAddr, oStall);
    end
    @(negedge iClk);
    iRst = 1'b0;
    exp_load = 32'h0;
    run_op(4'd5, 32'h100, 32'hCAFEF00D, 0, 0, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 80; n++) begin
      logic [3:0]  code;
      logic [31:0] a;
      int vd;
      code = 4'($urandom_range(0, 7));
      a    = $urandom;
      if ($urandom_range(0, 2) != 0)
        a = (code == 4'd0 || code == 4'd5) ? a & ~32'h3 :
            (code == 4'd1 || code == 4'd3 || code == 4'd6) ? a & ~32'h1 : a;
      vd = ($urandom_range(0, 9) == 0) ? $urandom_range(TO + 1, TO + 3) : $urandom_range(0, TO);
      run_op(code, a, $urandom, $urandom_range(0, 3), vd, $urandom, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_noop();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
